twiddle_stream_gen: RTL and testbench

- Parametrised, sequential successor to the fixed 8-entry twiddle tables.
- On a start pulse for a given radix-2 DIT stage, streams the N/2 twiddle factors of that stage in butterfly order over a valid/ready interface.
- Each beat carries the precomputed 3-multiplier operands: cos, -sin, cos-sin, cos+sin.
- Sits between the FFT stage controller and the complex butterfly multiplier.

---
 rtl/twiddle_stream_gen.sv | 184 ++++++++++++++++++
 tb/tb_twiddle_stream_gen.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/twiddle_stream_gen.sv
// Radix-2 DIT twiddle streamer: one stage's N/2 factors per start,
// carrying the 3-multiplier operands cos, -sin, cos-sin, cos+sin.
module twiddle_stream_gen #(
  parameter int N_LOG2 = 4,
  parameter int DATA_W = 8,
  parameter int OUT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [2:0]        stage,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N_LOG2-2:0] out_idx,
  output logic [OUT_W-1:0]  out_c,
  output logic [OUT_W-1:0]  out_s,
  output logic [OUT_W-1:0]  out_cps,
  output logic [OUT_W-1:0]  out_cms
);

  localparam int E_W    = N_LOG2 - 1;
  localparam int HALF   = 1 << (N_LOG2 - 1);
  localparam int QN     = 1 << (N_LOG2 - 2);
  localparam int STRIDE = 1 << (6 - N_LOG2);
  localparam int FS     = (1 << (DATA_W - 1)) - 1;

  localparam logic [N_LOG2-1:0] HALF_L = N_LOG2'(HALF);
  localparam logic [N_LOG2-1:0] QN_L   = N_LOG2'(QN);
  localparam logic [OUT_W-1:0]  FS_O   = OUT_W'(FS);

  // cos(k*pi/32) in Q24, floored; covers every grid up to N=64
  function automatic logic [24:0] base_cos(int k);
    case (k)
      0:  return 25'd16777216;
      1:  return 25'd16696429;
      2:  return 25'd16454846;
      3:  return 25'd16054794;
      4:  return 25'd15500126;
      5:  return 25'd14796183;
      6:  return 25'd13949745;
      7:  return 25'd12968963;
      8:  return 25'd11863283;
      9:  return 25'd10643353;
      10: return 25'd9320921;
      11: return 25'd7908724;
      12: return 25'd6420362;
      13: return 25'd4870168;
      14: return 25'd3273072;
      15: return 25'd1644454;
      default: return 25'd0;
    endcase
  endfunction

  // Magnitudes are non-negative, so the floor is the truncation
  function automatic logic [DATA_W-2:0] qval(int i);
    logic [63:0] p;
    p = 64'(FS) * 64'(base_cos(i * STRIDE));
    return (DATA_W-1)'(p >> 24);
  endfunction

  logic [DATA_W-2:0] qtab [QN+1];

  for (genvar i = 0; i <= QN; i++) begin : g_q
    assign qtab[i] = qval(i);
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIN
  } state_t;

  state_t            state;
  logic [N_LOG2-1:0] cnt;
  logic [2:0]        stg_q;

  logic [E_W-1:0]           mask;
  logic [E_W-1:0]           jm;
  logic [E_W-1:0]           ev;
  logic [N_LOG2-1:0]        ex;
  logic [N_LOG2-1:0]        ic;
  logic [N_LOG2-1:0]        is_;
  logic                     upper;
  logic [DATA_W-2:0]        qc;
  logic [DATA_W-2:0]        qs;
  logic signed [DATA_W-1:0] wr;
  logic signed [DATA_W-1:0] wi;
  logic [DATA_W:0]          cps;
  logic [DATA_W:0]          cms;
  logic [OUT_W-1:0]         c_ext;
  logic [OUT_W-1:0]         s_ext;
  logic [OUT_W-1:0]         cps_ext;
  logic [OUT_W-1:0]         cms_ext;

  // Operands of beat cnt: exponent, quarter-wave fold, sums
  always_comb begin
    mask  = ~({E_W{1'b1}} << stg_q);
    jm    = cnt[E_W-1:0] & mask;
    ev    = jm << (3'(E_W) - stg_q);
    ex    = {1'b0, ev};
    upper = ex > QN_L;
    ic    = upper ? HALF_L - ex : ex;
    is_   = upper ? ex - QN_L : QN_L - ex;
    qc    = qtab[ic[E_W-1:0]];
    qs    = qtab[is_[E_W-1:0]];
    wr    = upper ? -$signed({1'b0, qc})
                  : $signed({1'b0, qc});
    wi    = -$signed({1'b0, qs});
    cps   = {wr[DATA_W-1], wr} + {wi[DATA_W-1], wi};
    cms   = {wr[DATA_W-1], wr} - {wi[DATA_W-1], wi};
    c_ext = {{(OUT_W-DATA_W){wr[DATA_W-1]}}, wr};
    s_ext = {{(OUT_W-DATA_W){wi[DATA_W-1]}}, wi};
    cps_ext = {{(OUT_W-DATA_W-1){cps[DATA_W]}}, cps};
    cms_ext = {{(OUT_W-DATA_W-1){cms[DATA_W]}}, cms};
  end

  // Control FSM and output beat register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      stg_q     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_c     <= '0;
      out_s     <= '0;
      out_cps   <= '0;
      out_cms   <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            if (stage < 3'(N_LOG2)) begin
              // beat 0 is always e=0: cos=FS, sin=0
              stg_q     <= stage;
              state     <= S_RUN;
              busy      <= 1'b1;
              out_valid <= 1'b1;
              out_idx   <= '0;
              out_c     <= FS_O;
              out_s     <= '0;
              out_cps   <= FS_O;
              out_cms   <= FS_O;
              cnt       <= N_LOG2'(1);
            end else begin
              err <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (out_valid && out_ready && cnt == HALF_L) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= S_FIN;
          end else if ((!out_valid || out_ready) && cnt != HALF_L) begin
            out_valid <= 1'b1;
            out_idx   <= cnt[E_W-1:0];
            out_c     <= c_ext;
            out_s     <= s_ext;
            out_cps   <= cps_ext;
            out_cms   <= cms_ext;
            cnt       <= cnt + N_LOG2'(1);
          end
        end
        S_FIN: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_twiddle_stream_gen.sv
// Bench for twiddle_stream_gen: N=16 and N=64 instances checked
// against a trig-based reference and a table of known values.
module tb_twiddle_stream_gen;

  localparam real PI = 3.14159265358979;
  localparam real FS = 127.0;

  typedef struct {
    int idx;
    int c;
    int s;
    int cps;
    int cms;
  } beat_t;

  typedef struct {
    int stg;
    int j;
    int c;
    int s;
    int cps;
    int cms;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       start_a [2];
  logic [2:0] stage_a [2];
  logic       ready_a [2];

  logic        busy4, done4, err4, val4;
  logic [2:0]  idx4;
  logic [15:0] c4, s4, cps4, cms4;
  logic        busy6, done6, err6, val6;
  logic [4:0]  idx6;
  logic [15:0] c6, s6, cps6, cms6;

  twiddle_stream_gen #(.N_LOG2(4), .DATA_W(8), .OUT_W(16)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .start(start_a[0]), .stage(stage_a[0]),
    .busy(busy4), .done(done4), .err(err4),
    .out_valid(val4), .out_ready(ready_a[0]),
    .out_idx(idx4), .out_c(c4), .out_s(s4),
    .out_cps(cps4), .out_cms(cms4)
  );

  twiddle_stream_gen #(.N_LOG2(6), .DATA_W(8), .OUT_W(16)) dut6 (
    .clk(clk), .rst_n(rst_n),
    .start(start_a[1]), .stage(stage_a[1]),
    .busy(busy6), .done(done6), .err(err6),
    .out_valid(val6), .out_ready(ready_a[1]),
    .out_idx(idx6), .out_c(c6), .out_s(s6),
    .out_cps(cps6), .out_cms(cms6)
  );

  int vld [2];
  int bsy [2];
  int dn  [2];
  int er  [2];
  int idx [2];
  int oc  [2];
  int os  [2];
  int ocp [2];
  int ocm [2];

  always_comb begin
    vld[0] = int'(val4);  vld[1] = int'(val6);
    bsy[0] = int'(busy4); bsy[1] = int'(busy6);
    dn[0]  = int'(done4); dn[1]  = int'(done6);
    er[0]  = int'(err4);  er[1]  = int'(err6);
    idx[0] = int'(idx4);  idx[1] = int'(idx6);
    oc[0]  = int'($signed(c4));   oc[1]  = int'($signed(c6));
    os[0]  = int'($signed(s4));   os[1]  = int'($signed(s6));
    ocp[0] = int'($signed(cps4)); ocp[1] = int'($signed(cps6));
    ocm[0] = int'($signed(cms4)); ocm[1] = int'($signed(cms6));
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(string nm, int act, int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic beat_t model(int nl, int s, int j);
    beat_t b;
    int n, e, cv, sv;
    real a;
    n  = 1 << nl;
    e  = (j % (1 << s)) << (nl - 1 - s);
    a  = 2.0 * PI * e / n;
    cv = $rtoi(FS * $cos(a));
    sv = $rtoi(FS * $sin(a));
    b.idx = j;
    b.c   = cv;
    b.s   = -sv;
    b.cps = cv - sv;
    b.cms = cv + sv;
    return b;
  endfunction

  int    half [2] = '{8, 32};
  int    mode [2];
  int    rc   [2];
  int    nb   [2];
  int    ndone[2];
  int    nerr [2];
  logic  hold [2];
  beat_t saved[2];
  beat_t bq   [2][$];

  // ready driver: 0 = always, 1 = 1,0,0 pattern, 2 = random
  always @(posedge clk) begin
    #1;
    for (int k = 0; k < 2; k++) begin
      if (mode[k] == 0)
        ready_a[k] = 1'b1;
      else if (mode[k] == 1)
        ready_a[k] = (rc[k] % 3 == 0);
      else
        ready_a[k] = ($urandom % 3 != 0);
      rc[k]++;
    end
  end

  // monitor: stall stability, handshake capture, pulse counts
  always @(negedge clk) begin : mon
    beat_t cur;
    for (int k = 0; k < 2; k++) begin
      cur = '{idx[k], oc[k], os[k], ocp[k], ocm[k]};
      if (!rst_n) begin
        hold[k] = 1'b0;
      end else begin
        if (hold[k]) begin
          chk("stall_valid", vld[k], 1);
          chk("stall_idx", cur.idx, saved[k].idx);
          chk("stall_c", cur.c, saved[k].c);
          chk("stall_s", cur.s, saved[k].s);
          chk("stall_cps", cur.cps, saved[k].cps);
          chk("stall_cms", cur.cms, saved[k].cms);
        end
        if (vld[k] == 1 && ready_a[k]) begin
          bq[k].push_back(cur);
          nb[k]++;
        end
        if (dn[k] == 1) begin
          ndone[k]++;
          chk("done_after_last", nb[k], half[k]);
        end
        if (er[k] == 1) nerr[k]++;
        hold[k]  = (vld[k] == 1) && !ready_a[k];
        saved[k] = cur;
      end
    end
  end

  task automatic go(int k, int s);
    @(posedge clk);
    #1;
    nb[k] = 0;
    rc[k] = 0;
    bq[k].delete();
    start_a[k] = 1'b1;
    stage_a[k] = 3'(s);
    @(posedge clk);
    #1;
    start_a[k] = 1'b0;
  endtask

  task automatic wait_done(int k, int budget, output int cyc);
    cyc = 0;
    while (dn[k] == 0 && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    if (dn[k] == 0) chk("done_timeout", 0, 1);
  endtask

  task automatic cmp_stream(int k, int nl, int s);
    beat_t m;
    chk($sformatf("beat_count k%0d s%0d", k, s), bq[k].size(), half[k]);
    for (int j = 0; j < bq[k].size() && j < half[k]; j++) begin
      m = model(nl, s, j);
      chk($sformatf("idx k%0d s%0d j%0d", k, s, j), bq[k][j].idx, m.idx);
      chk($sformatf("c k%0d s%0d j%0d", k, s, j), bq[k][j].c, m.c);
      chk($sformatf("s k%0d s%0d j%0d", k, s, j), bq[k][j].s, m.s);
      chk($sformatf("cps k%0d s%0d j%0d", k, s, j), bq[k][j].cps, m.cps);
      chk($sformatf("cms k%0d s%0d j%0d", k, s, j), bq[k][j].cms, m.cms);
    end
  endtask

  task automatic chk_zero(int k, string tag);
    chk({tag, "_valid"}, vld[k], 0);
    chk({tag, "_busy"}, bsy[k], 0);
    chk({tag, "_done"}, dn[k], 0);
    chk({tag, "_err"}, er[k], 0);
    chk({tag, "_idx"}, idx[k], 0);
    chk({tag, "_c"}, oc[k], 0);
    chk({tag, "_s"}, os[k], 0);
    chk({tag, "_cps"}, ocp[k], 0);
    chk({tag, "_cms"}, ocm[k], 0);
  endtask

  vec_t tbl [24];
  int c3 [8] = '{127, 117, 89, 48, 0, -48, -89, -117};
  int s3 [8] = '{0, -48, -89, -117, -127, -117, -89, -48};
  int p3 [8] = '{127, 69, 0, -69, -127, -165, -178, -165};
  int m3 [8] = '{127, 165, 178, 165, 127, 69, 0, -69};
  int gstg [3] = '{3, 0, 1};

  initial begin
    int cyc, ne, nd, st, k, nl;
    vec_t v;
    beat_t b;

    for (int i = 0; i < 8; i++) begin
      tbl[i]     = '{3, i, c3[i], s3[i], p3[i], m3[i]};
      tbl[8 + i] = '{0, i, 127, 0, 127, 127};
      if (i % 2 == 0)
        tbl[16 + i] = '{1, i, 127, 0, 127, 127};
      else
        tbl[16 + i] = '{1, i, 0, -127, -127, 127};
    end

    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      start_a[i] = 1'b0;
      stage_a[i] = 3'd0;
      ready_a[i] = 1'b1;
      mode[i] = 0;
      rc[i] = 0;
      nb[i] = 0;
      ndone[i] = 0;
      nerr[i] = 0;
      hold[i] = 1'b0;
    end

    #3;
    chk_zero(0, "rst4");
    chk_zero(1, "rst6");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // full-throughput stage 3: latency and done timing
    go(0, 3);
    chk("first_valid", vld[0], 1);
    chk("first_busy", bsy[0], 1);
    chk("first_idx", idx[0], 0);
    wait_done(0, 50, cyc);
    chk("done_latency", cyc, 9);
    chk("busy_fall", bsy[0], 0);
    @(negedge clk);
    chk("done_width", dn[0], 0);

    // known-value table: stages 3, 0, 1
    for (int g = 0; g < 3; g++) begin
      if (g > 0) begin
        go(0, gstg[g]);
        wait_done(0, 50, cyc);
      end
      chk($sformatf("tbl_count s%0d", gstg[g]), bq[0].size(), 8);
      for (int i = 0; i < 8 && i < bq[0].size(); i++) begin
        v = tbl[g * 8 + i];
        b = bq[0][i];
        chk($sformatf("tbl_idx s%0d j%0d", v.stg, v.j), b.idx, v.j);
        chk($sformatf("tbl_c s%0d j%0d", v.stg, v.j), b.c, v.c);
        chk($sformatf("tbl_s s%0d j%0d", v.stg, v.j), b.s, v.s);
        chk($sformatf("tbl_cps s%0d j%0d", v.stg, v.j), b.cps, v.cps);
        chk($sformatf("tbl_cms s%0d j%0d", v.stg, v.j), b.cms, v.cms);
      end
    end

    // backpressure
    mode[0] = 1;
    nd = ndone[0];
    go(0, 3);
    wait_done(0, 200, cyc);
    cmp_stream(0, 4, 3);
    chk("bp_done_count", ndone[0], nd + 1);

    // illegal stage
    mode[0] = 0;
    ne = nerr[0];
    go(0, 4);
    chk("err_pulse", er[0], 1);
    chk("err_no_valid", vld[0], 0);
    chk("err_no_busy", bsy[0], 0);
    @(posedge clk);
    #1;
    chk("err_width", er[0], 0);
    repeat (3) @(negedge clk);
    chk("err_no_beats", bq[0].size(), 0);
    chk("err_count", nerr[0], ne + 1);

    // start during RUN and during DONE is ignored
    mode[0] = 1;
    ne = nerr[0];
    nd = ndone[0];
    go(0, 3);
    repeat (2) @(posedge clk);
    #1;
    start_a[0] = 1'b1;
    stage_a[0] = 3'd1;
    @(posedge clk);
    #1;
    start_a[0] = 1'b0;
    wait_done(0, 200, cyc);
    start_a[0] = 1'b1;
    stage_a[0] = 3'd2;
    @(posedge clk);
    #1;
    start_a[0] = 1'b0;
    cmp_stream(0, 4, 3);
    repeat (3) @(negedge clk);
    chk("ign_no_restart", vld[0], 0);
    chk("ign_not_busy", bsy[0], 0);
    chk("ign_no_err", nerr[0], ne);
    chk("ign_done_count", ndone[0], nd + 1);

    // asynchronous reset mid-stream
    mode[0] = 0;
    nd = ndone[0];
    go(0, 3);
    repeat (4) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk_zero(0, "async_rst");
    chk("rst_beats_before", bq[0].size(), 4);
    repeat (3) @(negedge clk);
    chk("rst_no_done", ndone[0], nd);
    rst_n = 1'b1;
    go(0, 3);
    wait_done(0, 50, cyc);
    cmp_stream(0, 4, 3);

    // N=64, last stage
    mode[1] = 0;
    go(1, 5);
    wait_done(1, 100, cyc);
    chk("n64_latency", cyc, 33);
    cmp_stream(1, 6, 5);
    if (bq[1].size() == 32) begin
      chk("n64_b16_c", bq[1][16].c, 0);
      chk("n64_b16_s", bq[1][16].s, -127);
      chk("n64_b8_c", bq[1][8].c, 89);
      chk("n64_b8_s", bq[1][8].s, -89);
      chk("n64_b8_cps", bq[1][8].cps, 0);
      for (int e = 1; e < 16; e++)
        chk($sformatf("n64_sym e%0d", e), bq[1][32 - e].c, -bq[1][e].c);
    end

    // random stages with random backpressure on both sizes
    for (int it = 0; it < 8; it++) begin
      k  = it % 2;
      nl = (k == 1) ? 6 : 4;
      st = $urandom_range(0, nl - 1);
      mode[k] = 2;
      go(k, st);
      wait_done(k, 400, cyc);
      cmp_stream(k, nl, st);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
